fifo_wr_arbiter_non2n: RTL and testbench
========================================

// Module: fifo_wr_arbiter_non2n
// PURPOSE
//  Round-robin arbiter sharing the single write port of the non-power-of-2 async FIFO among NUM_REQ producers.
//  Sits entirely in the write clock domain, between the producers and the FIFO wclk/w_en/wdata/full pins.
//  Grants one producer at a time for a burst of up to MAX_BURST beats, then rotates priority.
//  Never writes while the FIFO reports full.
// PARAMETERS
//  NUM_REQ     4    number of producers (2..8)
//  DATA_WIDTH  8    beat width, equal to the FIFO DATA_WIDTH
//  MAX_BURST   16   maximum beats per grant (1..255)
//  ID_WIDTH    2    grant index width, equal to clog2(NUM_REQ)
// PORTS
//  wclk        in   1                    write-domain clock; the only clock of this block
//  wrst        in   1                    asynchronous, active-high reset
//  req         in   NUM_REQ              per-producer request; held high with data stable until ack
//  req_data    in   NUM_REQ*DATA_WIDTH   flattened producer data; producer i occupies bits [i*DW +: DW]
//  ack         out  NUM_REQ              one-hot per-beat accept strobe
//  fifo_full   in   1                    FIFO full flag (wclk domain)
//  fifo_w_en   out  1                    FIFO write enable
//  fifo_wdata  out  DATA_WIDTH           FIFO write data
//  grant_id    out  ID_WIDTH             index of the current owner; valid while busy=1
//  busy        out  1                    a grant is active
// BEHAVIOUR
//  - Reset values: state=IDLE; ack=0, fifo_w_en=0, grant_id=0, busy=0; last-grant pointer=NUM_REQ-1; beat_cnt=0.
//  - Reset asserted mid-burst aborts the burst immediately; the producer simply sees no further ack.
//  - FSM IDLE: if any req bit is set, pick the first set bit searching from (last+1) mod NUM_REQ upward with wrap.
//    Register it into grant_id and last, clear beat_cnt, go to GRANT. Otherwise stay in IDLE.
//    Arbitration takes 1 cycle; there are no writes in IDLE.
//  - FSM GRANT: busy=1.
//    fifo_w_en = req[grant_id] & ~fifo_full (combinational).
//    ack[grant_id] = fifo_w_en; all other ack bits are 0.
//    fifo_wdata = req_data slice of grant_id (combinational mux, also driven in IDLE with index grant_id).
//    Each accepted beat increments beat_cnt (width clog2(MAX_BURST+1)).
//  - Leave GRANT for IDLE on the clock edge after either:
//    (a) the beat that makes beat_cnt == MAX_BURST, or
//    (b) a cycle in GRANT where req[grant_id]=0.
//    This gives a fixed 1-cycle bubble between grants.
//  - fifo_full=1 while in GRANT: no write, no ack, beat_cnt held, grant kept. There is no timeout.
//  - A producer dropping req during full also releases the grant, via rule (b).
//  - Simultaneous requests: only the round-robin order decides; no starvation.
//    Worst-case wait is (NUM_REQ-1)*(MAX_BURST+1) accepted-or-stalled grant cycles plus full stalls.
//  - MAX_BURST=1 degenerates to per-beat round robin.
//  - Never more than one ack bit high. fifo_w_en is never 1 when fifo_full=1.
// CONFIGURATION
//  - Macro FIFO_WR_ARB_STALL_CNT_EN.
//  - Defined: adds output stall_cnt[15:0], reset to 0.
//    It increments (saturating at 16'hFFFF) on every cycle in GRANT with req[grant_id]=1 and fifo_full=1.
//    Input stall_clr (1 bit, synchronous) zeroes it; clear wins over increment.
//  - Undefined: neither port exists, no counter logic is built, and all other behaviour is identical.
// STRUCTURE
//  - Package fifo_arb_pkg: state enum {IDLE, GRANT}, clog2 function, STALL_CNT_W=16 constant.
//  - One sub-module, rr_pick_non2n: combinational round-robin picker.
//    Inputs req and last; outputs found and idx. Reused by the planned read-side scheduler.
//  - Top: FSM, beat counter, data mux, ack decode, optional stall counter.
// TESTING
//  1. Reset: wrst=1 with req=4'b1111 -> ack=0, fifo_w_en=0, busy=0.
//     First grant after release goes to id 0 one cycle later.
//  2. req=4'b1111 held, full=0, MAX_BURST=16 -> 16 beats from id0, 1 idle cycle, then 16 from id1, then id2, id3, id0.
//  3. Only req[2] high, 3 beats then drop -> 3 acks.
//     Grant released the cycle after the drop; next grant goes to the next requester after 2.
//  4. fifo_full raised for 5 cycles mid-burst -> w_en/ack=0 for those 5 cycles.
//     beat_cnt frozen; burst resumes and totals 16 beats.
//     With the macro defined, stall_cnt=5.
//  5. Assert wrst during beat 7 of a burst -> outputs go to 0 asynchronously.
//     After release, arbitration restarts from id 0.
//  6. Random req/full for 1e5 cycles -> assert one-hot ack, no write while full.
//     Assert scoreboarded FIFO contents match the acked producer beats in order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types and helpers for the non-power-of-2 FIFO write
//             arbiter and its round-robin picker.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of the optional stall counter
  localparam int STALL_CNT_W = 16;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_non2n.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick_non2n
//  Purpose  : Combinational round-robin picker. Returns the first set request
//             bit searching upward from (last+1) mod NUM_REQ with wrap-around.
//             Works for any NUM_REQ, not only powers of two.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick_non2n
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  // Scan from farthest to nearest candidate so the nearest set bit wins last
  always_comb begin
    logic [ID_WIDTH-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(last) + k) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter_non2n.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter_non2n
//  Purpose  : Round-robin arbiter sharing the single write port of the
//             non-power-of-2 async FIFO among NUM_REQ producers. Grants one
//             producer for up to MAX_BURST beats, then rotates priority, with
//             a one-cycle arbitration bubble between grants. Never writes
//             while the FIFO is full.
//  Options  : FIFO_WR_ARB_STALL_CNT_EN adds stall_clr / stall_cnt, counting
//             cycles where the owner requests but the FIFO is full.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter_non2n
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  input  logic                          stall_clr,
  output logic [STALL_CNT_W-1:0]        stall_cnt
`endif
);

  localparam int BEAT_W = clog2(MAX_BURST + 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [ID_WIDTH-1:0] r_grant_id;
  logic [ID_WIDTH-1:0] r_last;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic                w_pick_found;
  logic [ID_WIDTH-1:0] w_pick_idx;
  logic                w_req_own;
  logic                w_w_en;
  logic                w_burst_done;

  rr_pick_non2n #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (req),
    .last  (r_last),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  assign w_req_own    = req[r_grant_id];
  assign busy         = (r_state == GRANT);
  assign w_w_en       = busy & w_req_own & ~fifo_full;
  // The accepted beat that brings the count up to MAX_BURST ends the burst
  assign w_burst_done = w_w_en && (r_beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign fifo_w_en    = w_w_en;
  assign fifo_wdata   = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id     = r_grant_id;

  // One-hot accept strobe to the current owner
  always_comb begin
    ack             = '0;
    ack[r_grant_id] = w_w_en;
  end

  // State register
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: arbitrate in IDLE, release on burst end or owner dropping req
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_found) w_state_nxt = GRANT;
      GRANT:   if (w_burst_done || !w_req_own) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant owner, round-robin pointer and beat counter
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_grant_id <= '0;
      r_last     <= ID_WIDTH'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else if (r_state == IDLE && w_pick_found) begin
      r_grant_id <= w_pick_idx;
      r_last     <= w_pick_idx;
      r_beat_cnt <= '0;
    end else if (w_w_en) begin
      r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of owner-requesting cycles blocked by a full FIFO
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (busy && w_req_own && fifo_full && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter_non2n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter_non2n
//  Purpose  : Directed self-checking bench for fifo_wr_arbiter_non2n
//             (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=16). Stall counter ports
//             are connected when FIFO_WR_ARB_STALL_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter_non2n;

  logic        wclk;
  logic        wrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_wdata;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic        stall_clr;
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter_non2n #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (16),
    .ID_WIDTH   (2)
  ) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_w_en  (fifo_w_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_clr  (stall_clr),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Single comparison point for the whole bench
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Fixed directed data: producer i presents 8'hA0+i
  function automatic logic [7:0] data_of(input int id);
    return 8'hA0 + 8'(id);
  endfunction

  // Count beats of the current grant to `id` until it releases, then check
  // the bubble cycle and the owner of the following grant
  task automatic run_burst(input int id, input int exp_beats, input int next_id);
    int beats;
    int cyc;
    logic [3:0] exp_ack;
    beats   = 0;
    cyc     = 0;
    exp_ack = 4'(1 << id);
    while (busy && cyc < 40) begin
      if (ack == exp_ack && fifo_wdata == data_of(id)) beats++;
      cyc++;
      tick();
    end
    check_val($sformatf("burst%0d_beats", id), beats, exp_beats);
    check_val($sformatf("burst%0d_bubble", id), {busy, ack}, 5'b0);
    tick();
    check_val($sformatf("burst%0d_next_id", id), {busy, 2'(grant_id)}, {1'b1, 2'(next_id)});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int beats, cyc, stalled, bad;
    int viol_onehot, viol_full, viol_noreq, viol_data;
    wrst      = 1'b1;
    req       = 4'b1111;
    req_data  = {data_of(3), data_of(2), data_of(1), data_of(0)};
    fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif

    // Reset state with all producers requesting
    tick();
    tick();
    check_val("rst_ack",  ack, 4'b0);
    check_val("rst_wen",  fifo_w_en, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_gid",  grant_id, 2'd0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check_val("rst_stall_cnt", stall_cnt, 16'd0);
`endif
    wrst = 1'b0;
    #1;
    check_val("idle_no_write", fifo_w_en, 1'b0);
    tick();
    check_val("first_grant", {busy, 2'(grant_id), ack}, {1'b1, 2'd0, 4'b0001});

    // Full round robin with all requesters and no back-pressure
    run_burst(0, 16, 1);
    run_burst(1, 16, 2);
    run_burst(2, 16, 3);
    run_burst(3, 16, 0);

    // Owner drops request: no write that cycle, grant released next edge
    req = 4'b0000;
    #1;
    check_val("drop_wen", fifo_w_en, 1'b0);
    tick();
    check_val("drop_release", busy, 1'b0);

    // Single requester 2: three beats then drop; last pointer is 0
    req = 4'b0100;
    tick();
    check_val("r2_grant", {busy, 2'(grant_id)}, {1'b1, 2'd2});
    beats = 0;
    for (int k = 0; k < 3; k++) begin
      if (ack == 4'b0100 && fifo_wdata == 8'hA2) beats++;
      tick();
    end
    check_val("r2_beats", beats, 3);
    req = 4'b0000;
    #1;
    check_val("r2_drop_ack", {busy, ack}, {1'b1, 4'b0000});
    tick();
    check_val("r2_release", busy, 1'b0);
    req = 4'b1011;
    tick();
    check_val("after2_grant", {busy, 2'(grant_id)}, {1'b1, 2'd3});
    req = 4'b0000;
    tick();
    check_val("after2_release", busy, 1'b0);

    // FIFO full for 5 cycles after 4 beats of a 16-beat burst
    req = 4'b0001;
    tick();
    check_val("full_grant", {busy, 2'(grant_id)}, {1'b1, 2'd0});
    beats = 0; cyc = 0; stalled = 0; bad = 0;
    while (busy && cyc < 60) begin
      fifo_full = (cyc >= 4 && cyc < 9);
      #1;
      if (ack == 4'b0001 && fifo_w_en) beats++;
      if (fifo_full && (ack != 4'b0 || fifo_w_en)) bad++;
      if (fifo_full && ack == 4'b0 && busy) stalled++;
      cyc++;
      tick();
    end
    fifo_full = 1'b0;
    check_val("full_beats",   beats, 16);
    check_val("full_stalled", stalled, 5);
    check_val("full_cycles",  cyc, 21);
    check_val("full_no_write", bad, 0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check_val("stall_cnt_5", stall_cnt, 16'd5);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    check_val("stall_cnt_clr", stall_cnt, 16'd0);
    req = 4'b0000;
    tick();
`endif

    // Asynchronous reset during beat 7; last pointer is 0 so id1 is next
    req = 4'b1111;
    tick();
    check_val("r5_grant", {busy, 2'(grant_id)}, {1'b1, 2'd1});
    for (int k = 0; k < 6; k++) tick();
    check_val("r5_beat7_ack", ack, 4'b0010);
    wrst = 1'b1;
    #1;
    check_val("r5_async_out", {busy, fifo_w_en, ack, 2'(grant_id)}, 8'b0);
    tick();
    wrst = 1'b0;
    tick();
    check_val("r5_restart", {busy, 2'(grant_id)}, {1'b1, 2'd0});

    // Random requests / back-pressure: protocol invariants
    viol_onehot = 0; viol_full = 0; viol_noreq = 0; viol_data = 0;
    for (int n = 0; n < 3000; n++) begin
      req       = 4'($urandom);
      req_data  = $urandom;
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      if ((ack & (ack - 4'd1)) != 4'd0) viol_onehot++;
      if (fifo_w_en && fifo_full) viol_full++;
      if ((ack & ~req) != 4'd0) viol_noreq++;
      if ((ack != 4'd0) != fifo_w_en) viol_onehot++;
      for (int i = 0; i < 4; i++) begin
        if (ack[i] && fifo_wdata != req_data[i*8 +: 8]) viol_data++;
      end
      tick();
    end
    check_val("rand_onehot", viol_onehot, 0);
    check_val("rand_full",   viol_full, 0);
    check_val("rand_noreq",  viol_noreq, 0);
    check_val("rand_data",   viol_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
